hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Consumer side of the ID/EX pipeline register.
- Compares decoded source registers in ID against the ID/EX destination and control bits to detect load-use hazards.
- Accepts taken-branch resolution from EX and issues stall, bubble and flush controls to the PC, the IF/ID register and the ID/EX register.
- Holds a small state machine for multi-cycle flush shadows and saturating performance counters.

Parameters:
- REG_ADDR_WIDTH, 5, register index width (from const.v).
- INST_ADDR_WIDTH, 32, instruction address width (from const.v).
- FLUSH_CYCLES, 1, cycles IF/ID is flushed per taken branch (1..3).
- CNT_WIDTH, 32, performance counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- id_rs1  in  REG_ADDR_WIDTH  rs1 of instruction in ID
- id_rs2  in  REG_ADDR_WIDTH  rs2 of instruction in ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_rd  in  REG_ADDR_WIDTH  ID/EX rd
- ex_memread  in  1  ID/EX MemRead
- ex_regwrite  in  1  ID/EX RegWrite
- ex_branch_taken  in  1  branch in EX resolved taken
- ex_branch_target  in  INST_ADDR_WIDTH  resolved target
- pc_write  out  1  PC update enable
- pc_sel  out  1  1 = load pc_target
- pc_target  out  INST_ADDR_WIDTH  redirect address
- if_id_write  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID clear to NOP
- id_ex_bubble  out  1  zero all ID/EX control inputs this edge
- stall_cnt  out  CNT_WIDTH  load-use stall cycles, saturating
- flush_cnt  out  CNT_WIDTH  taken-branch events, saturating

Behaviour:
- Load-use hazard (combinational): lu = ex_memread & ex_regwrite & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- States: RUN, SHADOW. Down-counter flush_left is 2 bits.
- Priority: taken branch > shadow > load-use.
- Taken branch, any state, ex_branch_taken=1:
  - outputs: pc_write=1, pc_sel=1, pc_target=ex_branch_target, if_id_flush=1, id_ex_bubble=1, if_id_write=1.
  - load-use is ignored because the ID instruction is squashed.
  - flush_cnt increments.
  - If FLUSH_CYCLES>1: next state SHADOW, flush_left=FLUSH_CYCLES-1. Otherwise stay in RUN.
  - A new taken branch inside SHADOW restarts the shadow.
- SHADOW, no branch:
  - outputs: if_id_flush=1, id_ex_bubble=1, pc_write=1, pc_sel=0.
  - load-use is ignored.
  - flush_left decrements. At 1, next state is RUN.
- RUN, lu=1:
  - outputs: pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0.
  - stall_cnt increments.
  - Next cycle ID/EX holds the bubble (ex_memread=0), so lu clears. Stall length is exactly 1 cycle per load-use.
- RUN, idle: pc_write=1, if_id_write=1, pc_sel=0, if_id_flush=0, id_ex_bubble=0.
- pc_target is combinational passthrough of ex_branch_target, qualified by pc_sel only.
- Counters saturate at all-ones and never wrap.
- Reset (asynchronous, any cycle including mid-shadow):
  - state=RUN, flush_left=0, stall_cnt=0, flush_cnt=0.
  - While rst is high, outputs take their RUN-idle values: pc_write=1, if_id_write=1, pc_sel=0, if_id_flush=0, id_ex_bubble=0.
- ex_rd==0 never stalls. An x0 destination is harmless.
- Simultaneous lu and ex_branch_taken: branch wins, and stall_cnt is unchanged.

Decomposition:
- Add state encoding localparams (HZ_RUN, HZ_SHADOW) and FLUSH_CYCLES default to const.v.
- Sub-module sat_counter (CNT_WIDTH, inc, rst) is instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Load-use stall:
  - Stimulus: ex_memread=1, ex_regwrite=1, ex_rd=5, id_rs1=5, id_uses_rs1=1. Next cycle drive ex_memread=0.
  - Required: one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1, then RUN. stall_cnt=1.
- x0 and unused operand:
  - Stimulus: ex_rd=0 with matching rs1. Separately, ex_rd=7, id_rs2=7, id_uses_rs2=0.
  - Required: no stall in either case. stall_cnt=0.
- Taken branch with FLUSH_CYCLES=1:
  - Stimulus: ex_branch_taken=1, target=0x00000040.
  - Required: pc_sel=1, pc_target=0x40, if_id_flush=1, id_ex_bubble=1 for 1 cycle. flush_cnt=1.
- Branch and load-use together:
  - Stimulus: lu and ex_branch_taken in the same cycle.
  - Required: flush outputs, pc_write=1, stall_cnt unchanged.
- FLUSH_CYCLES=3:
  - Stimulus: taken branch. Assert rst asynchronously in the 2nd shadow cycle.
  - Required: shadow flush outputs until reset. After reset, RUN-idle outputs and counters=0.
- Saturation:
  - Stimulus: CNT_WIDTH=4, 20 consecutive lu stalls (bubble released each cycle).
  - Required: stall_cnt stops at 15.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: default widths, flush shadow
// length and the controller state encoding.
package hazard_ctrl_pkg;

    localparam int REG_ADDR_WIDTH_DEF  = 5;
    localparam int INST_ADDR_WIDTH_DEF = 32;
    localparam int FLUSH_CYCLES_DEF    = 1;
    localparam int CNT_WIDTH_DEF       = 32;

    typedef enum logic {
        HZ_RUN    = 1'b0,
        HZ_SHADOW = 1'b1
    } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] count_r;

    // count register, held once it reaches the top code
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CNT_WIDTH{1'b0}};
        end else if (inc && (count_r != {CNT_WIDTH{1'b1}})) begin
            count_r <= count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/hazard_ctrl.sv
// ID/EX hazard controller: load-use stall detection, taken-branch redirect
// with an optional multi-cycle IF/ID flush shadow, and saturating event counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_WIDTH  = REG_ADDR_WIDTH_DEF,
    parameter int INST_ADDR_WIDTH = INST_ADDR_WIDTH_DEF,
    parameter int FLUSH_CYCLES    = FLUSH_CYCLES_DEF,
    parameter int CNT_WIDTH       = CNT_WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [REG_ADDR_WIDTH-1:0]  id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0]  id_rs2,
    input  logic                       id_uses_rs1,
    input  logic                       id_uses_rs2,
    input  logic [REG_ADDR_WIDTH-1:0]  ex_rd,
    input  logic                       ex_memread,
    input  logic                       ex_regwrite,
    input  logic                       ex_branch_taken,
    input  logic [INST_ADDR_WIDTH-1:0] ex_branch_target,
    output logic                       pc_write,
    output logic                       pc_sel,
    output logic [INST_ADDR_WIDTH-1:0] pc_target,
    output logic                       if_id_write,
    output logic                       if_id_flush,
    output logic                       id_ex_bubble,
    output logic [CNT_WIDTH-1:0]       stall_cnt,
    output logic [CNT_WIDTH-1:0]       flush_cnt
);

    // Shadow cycles remaining after the branch cycle itself.
    localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

    hz_state_e  state_r;
    hz_state_e  state_nxt_s;
    logic [1:0] flush_left_r;
    logic [1:0] flush_left_nxt_s;
    logic       lu_s;
    logic       stall_inc_s;
    logic       flush_inc_s;

    // An x0 destination can never create a real dependency.
    assign lu_s = ex_memread & ex_regwrite & (ex_rd != {REG_ADDR_WIDTH{1'b0}}) &
                  ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                   (id_uses_rs2 & (id_rs2 == ex_rd)));

    // state and shadow down-counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= HZ_RUN;
            flush_left_r <= 2'd0;
        end else begin
            state_r      <= state_nxt_s;
            flush_left_r <= flush_left_nxt_s;
        end
    end

    // next-state and pipeline control, priority branch > shadow > load-use
    always_comb begin
        state_nxt_s      = state_r;
        flush_left_nxt_s = flush_left_r;
        pc_write         = 1'b1;
        pc_sel           = 1'b0;
        if_id_write      = 1'b1;
        if_id_flush      = 1'b0;
        id_ex_bubble     = 1'b0;
        stall_inc_s      = 1'b0;
        flush_inc_s      = 1'b0;
        if (rst) begin
            state_nxt_s      = HZ_RUN;
            flush_left_nxt_s = 2'd0;
        end else if (ex_branch_taken) begin
            // The ID instruction is squashed, so a coincident load-use is moot.
            pc_sel       = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            flush_inc_s  = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_nxt_s      = HZ_SHADOW;
                flush_left_nxt_s = FLUSH_RELOAD;
            end else begin
                state_nxt_s      = HZ_RUN;
                flush_left_nxt_s = 2'd0;
            end
        end else begin
            case (state_r)
                HZ_SHADOW: begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    if (flush_left_r <= 2'd1) begin
                        state_nxt_s      = HZ_RUN;
                        flush_left_nxt_s = 2'd0;
                    end else begin
                        flush_left_nxt_s = flush_left_r - 2'd1;
                    end
                end
                HZ_RUN: begin
                    if (lu_s) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        stall_inc_s  = 1'b1;
                    end else begin
                        stall_inc_s  = 1'b0;
                    end
                end
                default: begin
                    state_nxt_s      = HZ_RUN;
                    flush_left_nxt_s = 2'd0;
                end
            endcase
        end
    end

    assign pc_target = pc_sel ? ex_branch_target : {INST_ADDR_WIDTH{1'b0}};

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc_s),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc_s),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances (1-cycle flush, 3-cycle
// flush, 4-bit counters) share stimulus but have independent resets.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst_a;
    logic        rst_b;
    logic        rst_c;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic [4:0]  ex_rd;
    logic        ex_memread;
    logic        ex_regwrite;
    logic        ex_branch_taken;
    logic [31:0] ex_branch_target;

    logic        pw_a, ps_a, iw_a, if_a, bb_a;
    logic        pw_b, ps_b, iw_b, if_b, bb_b;
    logic        pw_c, ps_c, iw_c, if_c, bb_c;
    logic [31:0] pt_a, pt_b, pt_c;
    logic [31:0] sc_a, fc_a, sc_b, fc_b;
    logic [3:0]  sc_c, fc_c;

    int total;
    int bad;

    hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_WIDTH(32)) u_dut_a (
        .clk(clk), .rst(rst_a), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
        .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
        .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
        .pc_write(pw_a), .pc_sel(ps_a), .pc_target(pt_a), .if_id_write(iw_a),
        .if_id_flush(if_a), .id_ex_bubble(bb_a), .stall_cnt(sc_a), .flush_cnt(fc_a)
    );

    hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_WIDTH(32)) u_dut_b (
        .clk(clk), .rst(rst_b), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
        .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
        .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
        .pc_write(pw_b), .pc_sel(ps_b), .pc_target(pt_b), .if_id_write(iw_b),
        .if_id_flush(if_b), .id_ex_bubble(bb_b), .stall_cnt(sc_b), .flush_cnt(fc_b)
    );

    hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_WIDTH(4)) u_dut_c (
        .clk(clk), .rst(rst_c), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
        .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
        .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
        .pc_write(pw_c), .pc_sel(ps_c), .pc_target(pt_c), .if_id_write(iw_c),
        .if_id_flush(if_c), .id_ex_bubble(bb_c), .stall_cnt(sc_c), .flush_cnt(fc_c)
    );

    // free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Control vector order: {pc_write, pc_sel, if_id_write, if_id_flush, id_ex_bubble}
    localparam logic [4:0] IDLE   = 5'b10100;
    localparam logic [4:0] STALL  = 5'b00001;
    localparam logic [4:0] BRANCH = 5'b11111;
    localparam logic [4:0] SHADOW = 5'b10111;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic apply(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                         input logic u2, input logic [4:0] rd, input logic mr,
                         input logic rw, input logic bt, input logic [31:0] tgt);
        @(negedge clk);
        id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        ex_rd = rd; ex_memread = mr; ex_regwrite = rw;
        ex_branch_taken = bt; ex_branch_target = tgt;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_rd = 5'd0; ex_memread = 1'b0; ex_regwrite = 1'b0;
        ex_branch_taken = 1'b0; ex_branch_target = 32'd0;
        tick();

        // load-use present while in reset: outputs must stay RUN-idle
        apply(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 32'd0);
        check_val("rst_outs", {27'd0, pw_a, ps_a, iw_a, if_a, bb_a}, {27'd0, IDLE});
        tick();
        check_val("rst_stall", sc_a, 32'd0);
        check_val("rst_flush", fc_a, 32'd0);
        apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        tick();

        // load-use stall for one cycle, then ID/EX holds the bubble
        apply(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 32'd0);
        check_val("lu_outs", {27'd0, pw_a, ps_a, iw_a, if_a, bb_a}, {27'd0, STALL});
        tick();
        check_val("lu_stall_cnt", sc_a, 32'd1);
        apply(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b1, 1'b0, 32'd0);
        check_val("lu_release", {27'd0, pw_a, ps_a, iw_a, if_a, bb_a}, {27'd0, IDLE});
        tick();
        check_val("lu_stall_once", sc_a, 32'd1);

        // x0 destination and unused rs2 never stall
        apply(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 32'd0);
        check_val("x0_outs", {27'd0, pw_a, ps_a, iw_a, if_a, bb_a}, {27'd0, IDLE});
        tick();
        apply(5'd3, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 32'd0);
        check_val("unused_rs2", {27'd0, pw_a, ps_a, iw_a, if_a, bb_a}, {27'd0, IDLE});
        tick();
        check_val("no_stall_cnt", sc_a, 32'd1);

        // taken branch: one flush cycle on A, shadow of two more cycles on B
        apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h0000_0040);
        check_val("br_outs", {27'd0, pw_a, ps_a, iw_a, if_a, bb_a}, {27'd0, BRANCH});
        check_val("br_target", pt_a, 32'h0000_0040);
        check_val("br_outs_b", {27'd0, pw_b, ps_b, iw_b, if_b, bb_b}, {27'd0, BRANCH});
        check_val("br_target_b", pt_b, 32'h0000_0040);
        tick();
        check_val("br_flush_cnt", fc_a, 32'd1);
        apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0040);
        check_val("br_after", {27'd0, pw_a, ps_a, iw_a, if_a, bb_a}, {27'd0, IDLE});
        check_val("br_target_gated", pt_a, 32'd0);
        check_val("shadow1_b", {27'd0, pw_b, ps_b, iw_b, if_b, bb_b}, {27'd0, SHADOW});
        tick();
        apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        check_val("shadow2_b", {27'd0, pw_b, ps_b, iw_b, if_b, bb_b}, {27'd0, SHADOW});
        // asynchronous reset in the middle of the shadow
        #1 rst_b = 1'b1;
        #1;
        check_val("async_rst_outs_b", {27'd0, pw_b, ps_b, iw_b, if_b, bb_b}, {27'd0, IDLE});
        check_val("async_rst_flush_b", fc_b, 32'd0);
        check_val("async_rst_stall_b", sc_b, 32'd0);
        tick();
        apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        rst_b = 1'b0;
        #1;
        check_val("post_rst_outs_b", {27'd0, pw_b, ps_b, iw_b, if_b, bb_b}, {27'd0, IDLE});
        tick();

        // branch and load-use together: branch wins, no stall counted
        apply(5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b1, 32'h0000_1234);
        check_val("br_lu_outs", {27'd0, pw_a, ps_a, iw_a, if_a, bb_a}, {27'd0, BRANCH});
        check_val("br_lu_target", pt_a, 32'h0000_1234);
        tick();
        check_val("br_lu_stall", sc_a, 32'd1);
        check_val("br_lu_flush", fc_a, 32'd2);
        // load-use while B is in shadow: ignored by B, stalls A
        apply(5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 32'd0);
        check_val("lu_in_shadow_b", {27'd0, pw_b, ps_b, iw_b, if_b, bb_b}, {27'd0, SHADOW});
        check_val("lu_run_a", {27'd0, pw_a, ps_a, iw_a, if_a, bb_a}, {27'd0, STALL});
        tick();
        check_val("shadow_stall_b", sc_b, 32'd0);
        check_val("run_stall_a", sc_a, 32'd2);
        apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        check_val("shadow_last_b", {27'd0, pw_b, ps_b, iw_b, if_b, bb_b}, {27'd0, SHADOW});
        tick();
        apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        check_val("shadow_exit_b", {27'd0, pw_b, ps_b, iw_b, if_b, bb_b}, {27'd0, IDLE});
        check_val("flush_b", fc_b, 32'd1);
        tick();

        // 20 back-to-back load-use stalls: 4-bit counter saturates at 15
        for (int i = 0; i < 20; i++) begin
            apply(5'd12, 5'd12, 1'b0, 1'b1, 5'd12, 1'b1, 1'b1, 1'b0, 32'd0);
            tick();
        end
        check_val("sat_stall_c", {28'd0, sc_c}, 32'd15);
        check_val("wide_stall_a", sc_a, 32'd22);
        check_val("wide_stall_b", sc_b, 32'd20);
        apply(5'd12, 5'd12, 1'b0, 1'b1, 5'd12, 1'b1, 1'b1, 1'b0, 32'd0);
        check_val("sat_outs_c", {27'd0, pw_c, ps_c, iw_c, if_c, bb_c}, {27'd0, STALL});
        tick();
        check_val("sat_hold_c", {28'd0, sc_c}, 32'd15);
        check_val("flush_c", {28'd0, fc_c}, 32'd2);
        apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0080);
        check_val("idle_target_c", pt_c, 32'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
